// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - LEGv8 fetch/execute sequencer owning the PC.
// Every output is a register or a copy of one, so no input reaches an output combinationally.
module pc_sequencer #(
   parameter int MAX_WAIT = 15
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [63:0] startPC,
   input  logic        run,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_instr,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        Branch,
   input  logic        ALUZero,
   input  logic        Uncondbranch,
   input  logic [63:0] SignExtImm64,
   output logic [63:0] PC,
   output logic [31:0] retired,
   output logic        fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   // Value of the wait counter on the last unacknowledged FETCH cycle allowed.
   localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_pc;
   logic [63:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] r_retired;
   logic [31:0] w_retired_nxt;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  w_wait_nxt;
   logic        r_req;
   logic        w_req_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic        r_fault;
   logic        w_fault_nxt;
   logic        w_take;

   always_ff @(posedge CLK) begin
      if (!resetl) begin
         r_state    <= S_IDLE;
         r_pc       <= startPC;
         r_instr    <= '0;
         r_retired  <= '0;
         r_wait_cnt <= '0;
         r_req      <= 1'b0;
         r_valid    <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_retired  <= w_retired_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_req      <= w_req_nxt;
         r_valid    <= w_valid_nxt;
         r_fault    <= w_fault_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt = (r_pc[1:0] == 2'b00) ? S_FETCH : S_FAULT;
            end
         end
         S_FETCH: begin
            // An ack on the final permitted cycle still wins over the timeout.
            if (imem_ack) begin
               w_state_nxt = S_EXEC;
            end else if (r_wait_cnt == LP_LAST_WAIT) begin
               w_state_nxt = S_FAULT;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               w_state_nxt = run ? S_FETCH : S_IDLE;
            end
         end
         S_FAULT: w_state_nxt = S_FAULT;
         default: w_state_nxt = S_FAULT;
      endcase
   end

   always_comb begin
      w_take        = Uncondbranch | (Branch & ALUZero);
      w_pc_nxt      = r_pc;
      w_instr_nxt   = r_instr;
      w_retired_nxt = r_retired;
      w_wait_nxt    = '0;
      case (r_state)
         S_FETCH: begin
            if (imem_ack) begin
               w_instr_nxt = imem_instr;
            end else begin
               w_wait_nxt = r_wait_cnt + 8'd1;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               w_pc_nxt      = w_take ? (r_pc + (SignExtImm64 << 2)) : (r_pc + 64'd4);
               w_retired_nxt = r_retired + 32'd1;
            end
         end
         default: ;
      endcase
      w_req_nxt   = (w_state_nxt == S_FETCH);
      w_valid_nxt = (r_state == S_FETCH) && (w_state_nxt == S_EXEC);
      w_fault_nxt = (w_state_nxt == S_FAULT);
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign PC          = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign retired     = r_retired;
   assign fault       = r_fault;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute sequencer that owns the program counter for the LEGv8 core. It issues instruction-memory fetches over a req/ack handshake and presents each fetched instruction to the datapath. It then waits for the datapath's execute-done strobe and advances the PC using the standard next-PC rule: PC+4, or a taken conditional/unconditional branch to PC + (imm<<2). It also counts retired instructions and latches a sticky fault on fetch timeout or misaligned start address.

## Interface
- MAX_WAIT, 15: maximum consecutive unacknowledged FETCH cycles before fault; legal range 1..255.
- CLK  in  1  rising-edge clock.
- resetl  in  1  reset, synchronous, active-low.
- startPC  in  64  PC value loaded while resetl=0.
- run  in  1  level enable; sequencing proceeds while high.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  64  fetch address; equals PC.
- imem_ack  in  1  memory accepts request and returns imem_instr in the same cycle.
- imem_instr  in  32  fetched instruction word.
- instr  out  32  latched instruction for decode.
- instr_valid  out  1  one-cycle pulse when instr is newly valid.
- exec_done  in  1  datapath finished the current instruction; branch inputs are sampled this cycle.
- Branch  in  1  conditional branch.
- ALUZero  in  1  ALU zero flag.
- Uncondbranch  in  1  unconditional branch.
- SignExtImm64  in  64  sign-extended word offset.
- PC  out  64  current program counter.
- retired  out  32  retired-instruction count; wraps.
- fault  out  1  sticky fault flag.

## Operation
- States: IDLE, FETCH, EXEC, FAULT.
- Reset (resetl=0 at a clock edge):
  - state=IDLE, PC=startPC.
  - imem_req=0, instr=0, instr_valid=0, retired=0, fault=0, wait_cnt=0.
  - Reset wins over every other event in any state, including mid-FETCH and mid-EXEC.
- IDLE:
  - run=1 and PC[1:0]==0: go to FETCH.
  - run=1 and PC[1:0]!=0: go to FAULT.
  - run=0: stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=PC for the whole state.
  - imem_ack=1: latch instr<=imem_instr, go to EXEC, clear wait_cnt.
  - No ack: wait_cnt increments.
  - MAX_WAIT consecutive unacked cycles: go to FAULT.
  - An ack in the MAX_WAIT-th cycle is accepted (ack wins).
  - run=0 during FETCH does not abandon the fetch.
- EXEC:
  - instr_valid=1 in the first EXEC cycle only.
  - Wait for exec_done; exec_done is accepted in any EXEC cycle, including the instr_valid cycle.
  - On exec_done:
    - If Uncondbranch | (Branch & ALUZero): PC <= PC + (SignExtImm64<<2).
    - Otherwise: PC <= PC + 4.
    - All arithmetic is 64-bit modulo 2^64, with no overflow detection.
    - retired <= retired + 1, wrapping at 2^32.
    - Next state is FETCH if run=1, else IDLE.
- FAULT:
  - Absorbing until reset.
  - imem_req=0, instr_valid=0; PC and retired are frozen.
  - fault=1.
- Don't-care inputs:
  - exec_done is ignored outside EXEC.
  - imem_ack is ignored outside FETCH.
  - Branch inputs matter only in the exec_done cycle.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- imem_req rises on the first cycle after entering FETCH. It remains high through the ack cycle and is low on the cycle after the ack.
- Zero-wait memory with same-cycle exec_done gives 2 cycles per instruction: one FETCH, one EXEC.
- IDLE to the first imem_req takes 1 cycle after run is sampled high.
- The PC update is visible on the cycle after the exec_done cycle, and imem_addr in the next FETCH equals the new PC.
- Simultaneous exec_done with run=0: the instruction retires and the block enters IDLE.
- fault rises on the cycle the state enters FAULT.

## Test plan
- Reset: startPC=0x1000, hold resetl=0 for 2 cycles.
  - Required: PC=0x1000; imem_req, instr_valid, retired and fault all 0.
  - Reassert resetl=0 mid-EXEC: PC returns to startPC and retired=0.
- Sequential: run=1, immediate ack with instr 0x8B020020, exec_done in the instr_valid cycle, no branches.
  - Required: imem_addr sequence 0x1000, 0x1004, 0x1008, with 2 cycles per instruction.
  - Required: retired=3 after the third exec_done.
- Branches, starting at PC=0x1008:
  - Uncondbranch=1, imm=-2 (0xFFFF...FFFE): PC=0x1000.
  - Branch=1, ALUZero=0, imm=3: PC=0x1004.
  - Branch=1, ALUZero=1, imm=3: PC=0x1010.
- Wait states, MAX_WAIT=15:
  - Ack on the 15th FETCH cycle: accepted, no fault.
  - No ack for 15 cycles: fault=1 on the next cycle, imem_req=0, PC unchanged.
  - Further acks and exec_done have no effect.
- Misaligned start: startPC=0x1002, run=1.
  - Required: FAULT one cycle after run is sampled, imem_req is never asserted, retired=0.
- run drop: deassert run during FETCH with ack delayed 3 cycles.
  - Required: the fetch completes, the instruction retires on exec_done, the block enters IDLE, and imem_req stays 0 afterward.
